speaker_envelope_drv: RTL and testbench
=======================================

// Module: speaker_envelope_drv
// PURPOSE
//  Output stage downstream of the music-box note generator. Takes its raw square-wave tone plus note
//  information, applies an attack/decay/sustain/release amplitude envelope by PWM-gating the tone,
//  and drives the bridged piezo pins spkp/spkm. Removes clicks and gives notes a shape; exports the
//  envelope level for LED metering.
// PARAMETERS
//  ENV_DIV      2500  clk cycles per envelope tick (100 us at 25 MHz); >=2
//  ATTACK_STEP  32    level increment per tick in ATTACK
//  DECAY_STEP   1     level decrement per tick in DECAY
//  SUSTAIN_LVL  160   level held in SUSTAIN; 0..255
//  RELEASE_STEP 4     level decrement per tick in RELEASE
// PORTS
//  clk        in   1  system clock (25 MHz PLL output)
//  resetn     in   1  asynchronous, active-low reset
//  tone_in    in   1  square-wave tone from note generator (synchronous to clk)
//  note_on    in   1  high while a note should sound (fullnote!=0 and gate)
//  note_code  in   8  current full note; a change while note_on is high retriggers
//  spkp       out  1  speaker plus pin, registered
//  spkm       out  1  speaker minus pin, registered
//  env_level  out  8  current envelope level, registered
//  env_active out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, env_level=0, prescaler=0, pwm_cnt=0, note_on_q=0, note_code_q=0,
//   spkp=0, spkm=0, env_active=0.
//  Prescaler free-runs 0..ENV_DIV-1; env_tick is high for 1 cycle when prescaler==ENV_DIV-1.
//  note_on_q/note_code_q are 1-cycle registered copies. trig = (note_on & ~note_on_q) |
//   (note_on & note_on_q & note_code!=note_code_q). rel = ~note_on & note_on_q.
//  State machine, evaluated every cycle, priority order:
//   rel in ATTACK/DECAY/SUSTAIN -> RELEASE (rel beats trig on the same cycle).
//   trig in any state -> ATTACK; level is NOT cleared (retrigger continues from current level).
//   No level step occurs on a cycle that takes a transition from trig or rel, even if env_tick.
//   ATTACK  on tick: level=min(level+ATTACK_STEP,255); reaching 255 -> DECAY.
//   DECAY   on tick: level=max(level-DECAY_STEP,SUSTAIN_LVL); reaching SUSTAIN_LVL -> SUSTAIN.
//   SUSTAIN: level held; exits only via rel/trig.
//   RELEASE on tick: level=max(level-RELEASE_STEP,0); reaching 0 -> IDLE.
//   IDLE: level=0; only trig leaves it.
//  Arithmetic uses 9-bit intermediates; saturates, never wraps.
//  PWM: 8-bit pwm_cnt free-runs, wrapping 255->0; pwm_on = (pwm_cnt < env_level).
//   Level 0 gives 0% duty; level 255 gives 255/256 duty.
//  Outputs are registered, 1 cycle after their inputs:
//   IDLE: spkp=0, spkm=0.
//   Otherwise: spkp = tone_in & pwm_on; spkm = ~tone_in & pwm_on (bridged drive).
//   spkp and spkm are never both 1.
//  env_active = (next state != IDLE), registered with state.
//  resetn assertion mid-note forces the reset values immediately (asynchronously) on all flops.
// STRUCTURE
//  Shared package music_pkg holds: env_state_t (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE),
//   ENV_W=8, ENV_MAX=8'd255, NOTE_W=8. The note generator and LED meter reuse it.
//  One sub-module: pwm_dac (8-bit counter + compare, output pwm_on). The prescaler, edge
//   detection, FSM and output register stay in this module.
// TESTING  (bench uses ENV_DIV=4, other parameters at defaults)
//  1 Reset: hold resetn=0, toggle tone_in -> spkp=spkm=0, env_level=0, env_active=0.
//  2 note_on 0->1 (note_code=25), hold -> ATTACK; level 32,64..224 then 255 after 8 ticks;
//     DECAY 254..160 (95 ticks); SUSTAIN holds at 160; spkp/spkm duty ~160/256 of the tone phase.
//  3 note_on 1->0 in SUSTAIN -> RELEASE; level 156,152..0 over 40 ticks, then IDLE;
//     env_active=0 and both pins 0.
//  4 note_code 25->27 while note_on=1 in DECAY at level 200 -> ATTACK from 200; 255 after 2 ticks.
//  5 Same cycle: note_on falls and note_code changes -> RELEASE (rel wins). Separately, note_on
//     rises during RELEASE at level 40 -> ATTACK from 40.
//  6 Assert resetn mid-ATTACK -> all outputs 0 immediately, without waiting for a clk edge; resumes
//     IDLE after release. Checker asserts !(spkp&spkm) on every cycle of every test.

Source files
------------

// File: rtl/music_pkg.sv
// Shared music-box definitions: envelope states and common widths.
// Used by the note generator, the speaker envelope driver and the LED meter.
package music_pkg;

   localparam int unsigned ENV_W  = 8;
   localparam int unsigned NOTE_W = 8;

   localparam logic [ENV_W-1:0] ENV_MAX = 8'd255;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

endpackage : music_pkg

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC: free-running counter compared against the envelope level.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   level        duty level (0 = off, 255 = 255/256 on)
//   pwm_on_c     combinational compare output (pwm_cnt < level)
module pwm_dac
   import music_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic [ENV_W-1:0] level,
   output logic             pwm_on_c
);

   logic [ENV_W-1:0] pwm_cnt_q;
   logic [ENV_W-1:0] pwm_cnt_d;

   // Counter wraps naturally from 255 to 0.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + ENV_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) pwm_cnt_q <= '0;
      else         pwm_cnt_q <= pwm_cnt_d;
   end

   assign pwm_on_c = (pwm_cnt_q < level);

endmodule : pwm_dac

// File: rtl/speaker_envelope_drv.sv
// ADSR envelope shaper and bridged piezo driver for the music-box tone.
// The raw square-wave tone is PWM-gated by the envelope level and driven
// differentially onto spkp/spkm.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   tone_in       square-wave tone from the note generator
//   note_on       high while a note sounds
//   note_code     current note; a change while note_on retriggers the attack
//   spkp, spkm    registered bridged speaker drive (never both high)
//   env_level     registered envelope level
//   env_active    registered, high whenever the envelope is not IDLE
module speaker_envelope_drv
   import music_pkg::*;
#(
   parameter int unsigned ENV_DIV      = 2500,
   parameter int unsigned ATTACK_STEP  = 32,
   parameter int unsigned DECAY_STEP   = 1,
   parameter int unsigned SUSTAIN_LVL  = 160,
   parameter int unsigned RELEASE_STEP = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              tone_in,
   input  logic              note_on,
   input  logic [NOTE_W-1:0] note_code,
   output logic              spkp,
   output logic              spkm,
   output logic [ENV_W-1:0]  env_level,
   output logic              env_active
);

   localparam int unsigned PRE_W = (ENV_DIV > 2) ? $clog2(ENV_DIV) : 1;
   localparam int unsigned EXT_W = ENV_W + 1;

   localparam logic [EXT_W-1:0] ATK_X  = EXT_W'(ATTACK_STEP);
   localparam logic [EXT_W-1:0] DEC_X  = EXT_W'(DECAY_STEP);
   localparam logic [EXT_W-1:0] SUS_X  = EXT_W'(SUSTAIN_LVL);
   localparam logic [EXT_W-1:0] REL_X  = EXT_W'(RELEASE_STEP);
   localparam logic [EXT_W-1:0] MAX_X  = EXT_W'(ENV_MAX);
   localparam logic [ENV_W-1:0] SUS_LV = ENV_W'(SUSTAIN_LVL);

   logic [PRE_W-1:0]  prescaler_q, prescaler_d;
   logic              note_on_q;
   logic [NOTE_W-1:0] note_code_q;
   env_state_t        state_q, state_d;
   logic [ENV_W-1:0]  level_q, level_d;
   logic              spkp_q, spkp_d;
   logic              spkm_q, spkm_d;
   logic              env_active_q, env_active_d;

   logic              env_tick_c;
   logic              trig_c;
   logic              rel_c;
   logic              pwm_on_c;
   logic [EXT_W-1:0]  level_x_c;
   logic [EXT_W-1:0]  level_up_c;

   // Envelope tick prescaler.
   assign env_tick_c = (prescaler_q == PRE_W'(ENV_DIV - 1));

   always_comb begin
      prescaler_d = env_tick_c ? '0 : prescaler_q + PRE_W'(1);
   end

   // Note start/retrigger and release detection.
   assign trig_c = (note_on & ~note_on_q) |
                   (note_on & note_on_q & (note_code != note_code_q));
   assign rel_c  = ~note_on & note_on_q;

   assign level_x_c  = {1'b0, level_q};
   assign level_up_c = level_x_c + ATK_X;

   // Envelope FSM; trig/rel transitions suppress the level step on that cycle.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (rel_c && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
         state_d = RELEASE;
      end else if (trig_c) begin
         state_d = ATTACK;
      end else begin
         unique case (state_q)
            IDLE: level_d = '0;
            ATTACK: if (env_tick_c) begin
               if (level_up_c >= MAX_X) begin
                  level_d = ENV_MAX;
                  state_d = DECAY;
               end else begin
                  level_d = level_up_c[ENV_W-1:0];
               end
            end
            DECAY: if (env_tick_c) begin
               if (level_x_c > SUS_X + DEC_X) begin
                  level_d = level_q - ENV_W'(DECAY_STEP);
               end else begin
                  level_d = SUS_LV;
                  state_d = SUSTAIN;
               end
            end
            SUSTAIN: level_d = level_q;
            RELEASE: if (env_tick_c) begin
               if (level_x_c > REL_X) begin
                  level_d = level_q - ENV_W'(RELEASE_STEP);
               end else begin
                  level_d = '0;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               level_d = '0;
            end
         endcase
      end
   end

   pwm_dac u_pwm_dac (
      .clk      (clk),
      .resetn   (resetn),
      .level    (level_q),
      .pwm_on_c (pwm_on_c)
   );

   // Bridged drive: tone phase selects the pin, PWM gates the amplitude.
   always_comb begin
      spkp_d       = 1'b0;
      spkm_d       = 1'b0;
      env_active_d = (state_d != IDLE);
      if (state_q != IDLE) begin
         spkp_d =  tone_in & pwm_on_c;
         spkm_d = ~tone_in & pwm_on_c;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prescaler_q  <= '0;
         note_on_q    <= 1'b0;
         note_code_q  <= '0;
         state_q      <= IDLE;
         level_q      <= '0;
         spkp_q       <= 1'b0;
         spkm_q       <= 1'b0;
         env_active_q <= 1'b0;
      end else begin
         prescaler_q  <= prescaler_d;
         note_on_q    <= note_on;
         note_code_q  <= note_code;
         state_q      <= state_d;
         level_q      <= level_d;
         spkp_q       <= spkp_d;
         spkm_q       <= spkm_d;
         env_active_q <= env_active_d;
      end
   end

   assign spkp       = spkp_q;
   assign spkm       = spkm_q;
   assign env_level  = level_q;
   assign env_active = env_active_q;

endmodule : speaker_envelope_drv

// File: tb/tb_speaker_envelope_drv.sv
// Directed bench for speaker_envelope_drv with a fast envelope tick (ENV_DIV=4).
module tb_speaker_envelope_drv;

   logic       clk = 1'b0;
   logic       resetn;
   logic       tone_in = 1'b0;
   logic       tone_seen = 1'b0;
   logic       note_on;
   logic [7:0] note_code;
   logic       spkp, spkm, env_active;
   logic [7:0] env_level;

   int n_cmp = 0;
   int n_err = 0;

   speaker_envelope_drv #(.ENV_DIV(4)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .tone_in    (tone_in),
      .note_on    (note_on),
      .note_code  (note_code),
      .spkp       (spkp),
      .spkm       (spkm),
      .env_level  (env_level),
      .env_active (env_active)
   );

   always #5 clk = ~clk;

   // Tone: 6-cycle square wave, changed away from both clock edges.
   initial begin
      forever begin
         repeat (3) @(posedge clk);
         #2 tone_in = ~tone_in;
      end
   end

   // Tone value the DUT sampled at the last rising edge.
   always @(posedge clk) tone_seen <= tone_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pins are exclusive and follow the tone phase on every cycle.
   always @(negedge clk) begin
      check("pins_exclusive", 32'(spkp & spkm), 32'd0);
      check("pin_polarity", 32'((spkp & ~tone_seen) | (spkm & tone_seen)), 32'd0);
   end

   // Wait (bounded) for the next level change and check its value.
   task automatic step_expect(input logic [7:0] exp, input string tag);
      logic [7:0] prev;
      int k;
      prev = env_level;
      k = 0;
      while (env_level === prev && k < 20) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(env_level), 32'(exp));
   endtask

   initial begin
      int dc;
      int v;
      resetn    = 1'b0;
      note_on   = 1'b0;
      note_code = 8'd0;

      // 1: reset holds everything quiet while the tone toggles
      repeat (8) @(negedge clk);
      check("rst_spkp", 32'(spkp), 32'd0);
      check("rst_spkm", 32'(spkm), 32'd0);
      check("rst_level", 32'(env_level), 32'd0);
      check("rst_active", 32'(env_active), 32'd0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_level", 32'(env_level), 32'd0);
      check("idle_active", 32'(env_active), 32'd0);

      // 2: attack, decay, sustain
      note_code = 8'd25;
      note_on   = 1'b1;
      @(negedge clk);
      check("trig_active", 32'(env_active), 32'd1);
      check("trig_no_step", 32'(env_level), 32'd0);
      for (int i = 1; i <= 7; i++) step_expect(8'(32 * i), "attack_step");
      step_expect(8'd255, "attack_sat");
      for (int i = 254; i >= 160; i--) step_expect(8'(i), "decay_step");
      repeat (2) @(negedge clk);
      dc = 0;
      repeat (256) begin
         @(negedge clk);
         dc += int'(spkp | spkm);
      end
      check("sustain_duty", 32'(dc), 32'd160);
      check("sustain_hold", 32'(env_level), 32'd160);
      check("sustain_active", 32'(env_active), 32'd1);

      // 3: release to idle
      note_on = 1'b0;
      for (int i = 156; i >= 0; i -= 4) step_expect(8'(i), "release_step");
      check("release_idle", 32'(env_active), 32'd0);
      repeat (2) @(negedge clk);
      check("idle_spkp", 32'(spkp), 32'd0);
      check("idle_spkm", 32'(spkm), 32'd0);

      // 4: note change in decay retriggers from current level
      note_on = 1'b1;
      for (int i = 1; i <= 7; i++) step_expect(8'(32 * i), "attack2_step");
      step_expect(8'd255, "attack2_sat");
      for (int i = 254; i >= 200; i--) step_expect(8'(i), "decay2_step");
      note_code = 8'd27;
      step_expect(8'd232, "retrig_from_200");
      step_expect(8'd255, "retrig_sat");
      step_expect(8'd254, "decay3_254");
      step_expect(8'd253, "decay3_253");
      step_expect(8'd252, "decay3_252");

      // 5: release and note change together -> release wins
      note_on   = 1'b0;
      note_code = 8'd30;
      step_expect(8'd248, "rel_wins");
      v = 244;
      while (v >= 40) begin
         step_expect(8'(v), "release2_step");
         v -= 4;
      end
      note_on = 1'b1;
      step_expect(8'd72, "retrig_from_40");
      step_expect(8'd104, "retrig_40_next");
      check("retrig_active", 32'(env_active), 32'd1);

      // 6: asynchronous reset mid-attack
      #1 resetn = 1'b0;
      #1;
      check("async_spkp", 32'(spkp), 32'd0);
      check("async_spkm", 32'(spkm), 32'd0);
      check("async_level", 32'(env_level), 32'd0);
      check("async_active", 32'(env_active), 32'd0);
      note_on = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_level", 32'(env_level), 32'd0);
      check("post_rst_active", 32'(env_active), 32'd0);
      check("post_rst_spkp", 32'(spkp), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_speaker_envelope_drv
